// File: rtl/cache_axi_pkg.sv
// Shared Dcache/AXI-side types: read/write type codes, line geometry and the write-buffer entry.
package cache_axi_pkg;
  localparam logic [2:0] RT_BYTE = 3'b000;
  localparam logic [2:0] RT_HALF = 3'b001;
  localparam logic [2:0] RT_WORD = 3'b010;
  localparam logic [2:0] RT_LINE = 3'b100;

  localparam int LINE_OFF_W = 4;
  localparam int TAG_W      = 32 - LINE_OFF_W;

  typedef struct packed {
    logic         valid;
    logic [2:0]   wr_type;
    logic [31:0]  addr;
    logic [3:0]   wstrb;
    logic [127:0] data;
  } wbuf_entry_t;
endpackage

// File: rtl/wbuf_line_match.sv
// DEPTH-way 16-byte-line compare of a read address against buffered (and in-flight) writes.
module wbuf_line_match
  import cache_axi_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic [DEPTH-1:0]            ent_valid,
  input  logic [DEPTH-1:0][TAG_W-1:0] ent_tag,
  input  logic                        push,
  input  logic [TAG_W-1:0]            push_tag,
  input  logic                        rd_req,
  input  logic [TAG_W-1:0]            rd_tag,
  output logic                        hit
);
  logic [DEPTH-1:0] match;

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    assign match[i] = ent_valid[i] && (ent_tag[i] == rd_tag);
  end

  // A write landing this edge is not yet valid in storage but must still block.
  assign hit = rd_req && ((|match) || (push && (push_tag == rd_tag)));
endmodule

// File: rtl/dcache_wbuf.sv
// Dcache write buffer: FIFO of writes toward the AXI bridge with line-granular RAW read blocking.
// Optional perf counters behind `define WBUF_PERF_EN.
module dcache_wbuf
  import cache_axi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         in_wr_req,
  input  logic [2:0]   in_wr_type,
  input  logic [31:0]  in_wr_addr,
  input  logic [3:0]   in_wr_wstrb,
  input  logic [127:0] in_wr_data,
  output logic         in_wr_rdy,
  input  logic         in_rd_req,
  input  logic [2:0]   in_rd_type,
  input  logic [31:0]  in_rd_addr,
  output logic         in_rd_rdy,
  output logic         out_wr_req,
  output logic [2:0]   out_wr_type,
  output logic [31:0]  out_wr_addr,
  output logic [3:0]   out_wr_wstrb,
  output logic [127:0] out_wr_data,
  input  logic         out_wr_rdy,
  output logic         out_rd_req,
  output logic [2:0]   out_rd_type,
  output logic [31:0]  out_rd_addr,
  input  logic         out_rd_rdy,
  output logic         wbuf_empty
`ifdef WBUF_PERF_EN
  ,
  output logic [31:0]  perf_wr_cnt,
  output logic [31:0]  perf_stall_cnt,
  output logic [31:0]  perf_full_cnt
`endif
);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  wbuf_entry_t      ent [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   count;
  logic             push, pop, hit;

  logic [DEPTH-1:0]            ent_valid;
  logic [DEPTH-1:0][TAG_W-1:0] ent_tag;

  // Ready/empty come from count only, so no combinational path from out_wr_rdy.
  assign in_wr_rdy  = (count != DEPTH_C);
  assign out_wr_req = (count != '0);
  assign wbuf_empty = (count == '0);
  assign push       = in_wr_req && in_wr_rdy;
  assign pop        = out_wr_req && out_wr_rdy;

  assign out_wr_type  = ent[rptr].wr_type;
  assign out_wr_addr  = ent[rptr].addr;
  assign out_wr_wstrb = ent[rptr].wstrb;
  assign out_wr_data  = ent[rptr].data;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      if (pop) begin
        ent[rptr].valid <= 1'b0;
        rptr            <= rptr + PTR_W'(1);
      end
      if (push) begin
        ent[wptr] <= '{valid: 1'b1, wr_type: in_wr_type, addr: in_wr_addr,
                       wstrb: in_wr_wstrb, data: in_wr_data};
        wptr      <= wptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_tag
    assign ent_valid[i] = ent[i].valid;
    assign ent_tag[i]   = ent[i].addr[31:LINE_OFF_W];
  end

  wbuf_line_match #(.DEPTH(DEPTH)) u_match (
    .ent_valid (ent_valid),
    .ent_tag   (ent_tag),
    .push      (push),
    .push_tag  (in_wr_addr[31:LINE_OFF_W]),
    .rd_req    (in_rd_req),
    .rd_tag    (in_rd_addr[31:LINE_OFF_W]),
    .hit       (hit)
  );

  assign out_rd_req  = in_rd_req && !hit;
  assign in_rd_rdy   = out_rd_rdy && !hit;
  assign out_rd_type = in_rd_type;
  assign out_rd_addr = in_rd_addr;

`ifdef WBUF_PERF_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
      perf_full_cnt  <= '0;
    end else begin
      if (push && perf_wr_cnt != '1)                      perf_wr_cnt    <= perf_wr_cnt + 32'd1;
      if (hit && perf_stall_cnt != '1)                    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (in_wr_req && !in_wr_rdy && perf_full_cnt != '1) perf_full_cnt  <= perf_full_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_wbuf.sv
// Bench for dcache_wbuf: directed scenarios then random traffic against a queue-based reference model.
module tb_dcache_wbuf;
  import cache_axi_pkg::*;
  localparam int DEPTH = 2;

  logic aclk = 1'b0, aresetn = 1'b0;
  logic in_wr_req = 0, in_rd_req = 0, out_wr_rdy = 0, out_rd_rdy = 0;
  logic [2:0] in_wr_type = 0, in_rd_type = 0;
  logic [31:0] in_wr_addr = 0, in_rd_addr = 0;
  logic [3:0] in_wr_wstrb = 0;
  logic [127:0] in_wr_data = 0;
  logic in_wr_rdy, in_rd_rdy, out_wr_req, out_rd_req, wbuf_empty;
  logic [2:0] out_wr_type, out_rd_type;
  logic [31:0] out_wr_addr, out_rd_addr;
  logic [3:0] out_wr_wstrb;
  logic [127:0] out_wr_data;
`ifdef WBUF_PERF_EN
  logic [31:0] perf_wr_cnt, perf_stall_cnt, perf_full_cnt;
`endif

  always #5 aclk = ~aclk;

  dcache_wbuf #(.DEPTH(DEPTH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .in_wr_req(in_wr_req), .in_wr_type(in_wr_type), .in_wr_addr(in_wr_addr),
    .in_wr_wstrb(in_wr_wstrb), .in_wr_data(in_wr_data), .in_wr_rdy(in_wr_rdy),
    .in_rd_req(in_rd_req), .in_rd_type(in_rd_type), .in_rd_addr(in_rd_addr), .in_rd_rdy(in_rd_rdy),
    .out_wr_req(out_wr_req), .out_wr_type(out_wr_type), .out_wr_addr(out_wr_addr),
    .out_wr_wstrb(out_wr_wstrb), .out_wr_data(out_wr_data), .out_wr_rdy(out_wr_rdy),
    .out_rd_req(out_rd_req), .out_rd_type(out_rd_type), .out_rd_addr(out_rd_addr),
    .out_rd_rdy(out_rd_rdy), .wbuf_empty(wbuf_empty)
`ifdef WBUF_PERF_EN
    , .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt), .perf_full_cnt(perf_full_cnt)
`endif
  );

  typedef struct {
    logic [2:0]   t;
    logic [31:0]  a;
    logic [3:0]   s;
    logic [127:0] d;
  } ent_t;
  ent_t q[$];

  int n_chk = 0, n_fail = 0;
  int m_wr = 0, m_stall = 0, m_full = 0;
  logic exp_push, exp_pop, exp_hit, exp_rdy;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected behaviour from the buffer contents: FIFO order, capacity DEPTH, line-granular blocking.
  task automatic check_outputs();
    exp_rdy  = (q.size() < DEPTH);
    exp_push = in_wr_req && exp_rdy;
    exp_pop  = (q.size() != 0) && out_wr_rdy;
    exp_hit  = 1'b0;
    foreach (q[i]) if (q[i].a[31:4] == in_rd_addr[31:4]) exp_hit = 1'b1;
    if (exp_push && in_wr_addr[31:4] == in_rd_addr[31:4]) exp_hit = 1'b1;
    exp_hit = exp_hit && in_rd_req;
    chk("in_wr_rdy", in_wr_rdy, exp_rdy);
    chk("out_wr_req", out_wr_req, q.size() != 0);
    chk("wbuf_empty", wbuf_empty, q.size() == 0);
    chk("out_rd_req", out_rd_req, in_rd_req && !exp_hit);
    chk("in_rd_rdy", in_rd_rdy, out_rd_rdy && !exp_hit);
    chk("out_rd_type", out_rd_type, in_rd_type);
    chk("out_rd_addr", out_rd_addr, in_rd_addr);
    if (q.size() != 0) begin
      chk("out_wr_type", out_wr_type, q[0].t);
      chk("out_wr_addr", out_wr_addr, q[0].a);
      chk("out_wr_wstrb", out_wr_wstrb, q[0].s);
      chk("out_wr_data", out_wr_data, q[0].d);
    end
  endtask

  // Entered just after a negedge with inputs already driven; leaves at the next negedge.
  task automatic tick();
    ent_t e;
    #1 check_outputs();
    @(posedge aclk);
    e = '{t: in_wr_type, a: in_wr_addr, s: in_wr_wstrb, d: in_wr_data};
    if (exp_pop) void'(q.pop_front());
    if (exp_push) q.push_back(e);
    if (exp_push) m_wr++;
    if (exp_hit) m_stall++;
    if (in_wr_req && !exp_rdy) m_full++;
    @(negedge aclk);
  endtask

  task automatic drv_wr(input logic [2:0] t, input logic [31:0] a);
    in_wr_req   = 1'b1;
    in_wr_type  = t;
    in_wr_addr  = a;
    in_wr_wstrb = 4'($urandom);
    in_wr_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic push_wait();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!exp_push && n < 50);
    if (!exp_push) chk("push_timeout", 1'b0, 1'b1);
    in_wr_req = 1'b0;
  endtask

  initial begin
    logic [31:0]  h_addr;
    logic [127:0] h_data;
    logic [2:0]   h_type;

    // Reset state
    #12;
    chk("rst_out_wr_req", out_wr_req, 1'b0);
    chk("rst_in_wr_rdy", in_wr_rdy, 1'b1);
    chk("rst_wbuf_empty", wbuf_empty, 1'b1);
    chk("rst_out_rd_req", out_rd_req, 1'b0);
    chk("rst_out_wr_addr", out_wr_addr, 32'h0);
    chk("rst_out_wr_data", out_wr_data, 128'h0);
    @(negedge aclk);
    aresetn = 1'b1;
    tick();

    // Single line write drains one cycle after push
    out_wr_rdy = 1'b1;
    drv_wr(RT_LINE, 32'h1C00_0040);
    tick();
    in_wr_req = 1'b0;
    #1;
    chk("single_req", out_wr_req, 1'b1);
    chk("single_addr", out_wr_addr, 32'h1C00_0040);
    chk("single_type", out_wr_type, RT_LINE);
    tick();
    #1 chk("single_empty", wbuf_empty, 1'b1);
    tick();

    // Fill to DEPTH with bridge stalled; third write held until head pops
    out_wr_rdy = 1'b0;
    drv_wr(RT_WORD, 32'h1C00_0100); push_wait();
    drv_wr(RT_BYTE, 32'h1C00_0204); push_wait();
    #1 chk("full_rdy", in_wr_rdy, 1'b0);
    drv_wr(RT_HALF, 32'h1C00_0302);
    tick(); tick();
    out_wr_rdy = 1'b1;
    push_wait();
    repeat (4) tick();

    // RAW hazard on same line; other line bypasses
    out_wr_rdy = 1'b0;
    drv_wr(RT_LINE, 32'h1C00_0040); push_wait();
    in_rd_req = 1'b1; in_rd_type = RT_WORD; in_rd_addr = 32'h1C00_004C; out_rd_rdy = 1'b1;
    #1;
    chk("haz_out_rd_req", out_rd_req, 1'b0);
    chk("haz_in_rd_rdy", in_rd_rdy, 1'b0);
    tick(); tick();
    in_rd_addr = 32'h1C00_0080;
    #1;
    chk("bypass_out_rd_req", out_rd_req, 1'b1);
    chk("bypass_in_rd_rdy", in_rd_rdy, 1'b1);
    tick();
    in_rd_addr = 32'h1C00_004C;
    out_wr_rdy = 1'b1;
    tick(); tick();
    in_rd_req = 1'b0;

    // Head stable under backpressure, pops on first ready cycle
    out_wr_rdy = 1'b0;
    drv_wr(RT_WORD, 32'h1C00_0500); push_wait();
    #1;
    h_addr = out_wr_addr; h_data = out_wr_data; h_type = out_wr_type;
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("stall_addr", out_wr_addr, h_addr);
      chk("stall_data", out_wr_data, h_data);
      chk("stall_type", out_wr_type, h_type);
    end
    out_wr_rdy = 1'b1;
    tick();
    #1 chk("stall_popped", wbuf_empty, 1'b1);
    tick();

    // Asynchronous reset with two entries buffered
    out_wr_rdy = 1'b0;
    drv_wr(RT_LINE, 32'h1C00_0600); push_wait();
    drv_wr(RT_LINE, 32'h1C00_0700); push_wait();
    #3 aresetn = 1'b0;
    #1;
    chk("arst_out_wr_req", out_wr_req, 1'b0);
    chk("arst_wbuf_empty", wbuf_empty, 1'b1);
    chk("arst_in_wr_rdy", in_wr_rdy, 1'b1);
    q.delete();
    m_wr = 0; m_stall = 0; m_full = 0;
    @(negedge aclk);
    aresetn = 1'b1;
    out_wr_rdy = 1'b1;
    repeat (3) tick();

    // Random traffic over a few lines so hazards and full cycles are frequent
    for (int c = 0; c < 1500; c++) begin
      in_wr_req   = 1'($urandom);
      in_wr_type  = ($urandom_range(0, 3) == 0) ? RT_LINE : 3'($urandom_range(0, 2));
      in_wr_addr  = 32'h1C00_0000 | (32'($urandom_range(0, 3)) << 4) | ($urandom & 32'hC);
      in_wr_wstrb = 4'($urandom);
      in_wr_data  = {$urandom, $urandom, $urandom, $urandom};
      out_wr_rdy  = ($urandom_range(0, 2) != 0);
      in_rd_req   = 1'($urandom);
      in_rd_type  = 3'($urandom_range(0, 4));
      in_rd_addr  = 32'h1C00_0000 | (32'($urandom_range(0, 5)) << 4) | ($urandom & 32'hF);
      out_rd_rdy  = 1'($urandom);
      tick();
    end

`ifdef WBUF_PERF_EN
    #1;
    chk("perf_wr_cnt", perf_wr_cnt, 32'(m_wr));
    chk("perf_stall_cnt", perf_stall_cnt, 32'(m_stall));
    chk("perf_full_cnt", perf_full_cnt, 32'(m_full));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dcache_wbuf.md
Name: dcache_wbuf

Overview:
- Write buffer between the Dcache AXI-side read/write interface and the AXI bridge.
- Queues Dcache writes (dirty-line writebacks, wr_type 3'b100; uncached stores, wr_type 3'b000/001/010) so a refill read can be issued before the victim drains.
- Blocks any Dcache read whose 16-byte line matches a buffered write until that write has drained, preserving read-after-write order.
- Icache traffic does not pass through this block.

Parameters:
DEPTH, 2, number of buffered write entries; power of two, 2..8
PTR_W, $clog2(DEPTH), FIFO pointer width

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
in_wr_req  in  1  Dcache write request
in_wr_type  in  3  write type (3'b100 line; otherwise single word)
in_wr_addr  in  32  write physical address
in_wr_wstrb  in  4  byte strobe (word writes)
in_wr_data  in  128  write data (word writes use [31:0])
in_wr_rdy  out  1  buffer can accept a write
in_rd_req  in  1  Dcache read request
in_rd_type  in  3  read type
in_rd_addr  in  32  read physical address
in_rd_rdy  out  1  read accepted by bridge and not hazard-blocked
out_wr_req  out  1  head entry valid toward bridge
out_wr_type  out  3  head type
out_wr_addr  out  32  head address
out_wr_wstrb  out  4  head strobe
out_wr_data  out  128  head data
out_wr_rdy  in  1  bridge accepts write
out_rd_req  out  1  read forwarded to bridge
out_rd_type  out  3  forwarded read type
out_rd_addr  out  32  forwarded read address
out_rd_rdy  in  1  bridge read ready
wbuf_empty  out  1  no entries buffered (cacop/ibar drain check)

Behaviour:
- Clocking and reset: one clock, aclk. Reset is asynchronous, active-low on aresetn. Reset clears all valid bits and pointers and discards any in-flight entries; no partial drain afterwards.
- Reset values: out_wr_req=0, in_wr_rdy=1, wbuf_empty=1, out_rd_req=0. All payload outputs are 0.
- Storage: circular FIFO of DEPTH entries {type, addr, wstrb, data, valid}, with wptr, rptr and count (PTR_W+1 bits). Pointers wrap modulo DEPTH.
- Push: on in_wr_req && in_wr_rdy. Entry is written at wptr the same edge.
- in_wr_rdy = (count != DEPTH). It is registered-state only, with no combinational path from out_wr_rdy. When full, a push is refused even if a pop occurs the same cycle.
- Drain: out_wr_req = (count != 0). out_wr_* come directly from the entry at rptr.
- Pop: on out_wr_req && out_wr_rdy. Head payload must stay stable while out_wr_req && !out_wr_rdy.
- Latency: a write pushed at edge N is presented on out_wr_* from cycle N+1 when the buffer was empty.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Hazard: hit = in_rd_req && OR over valid entries of (entry.addr[31:4] == in_rd_addr[31:4]).
  - The compare also covers an entry being pushed in the same cycle.
  - An entry popped in the same cycle still counts as a hit (conservative).
- Read pass-through: out_rd_req = in_rd_req && !hit; in_rd_rdy = out_rd_rdy && !hit; type and addr are passed combinationally.
- Read/write ordering: writes are never reordered among themselves. Non-conflicting reads may bypass buffered writes.
- wbuf_empty = (count == 0), registered-state only.

Optional Feature:
- Macro: WBUF_PERF_EN.
- When defined, adds three outputs:
  - perf_wr_cnt [31:0]: accepted pushes.
  - perf_stall_cnt [31:0]: cycles with in_rd_req && hit.
  - perf_full_cnt [31:0]: cycles with in_wr_req && !in_wr_rdy.
- Counters saturate at 32'hFFFF_FFFF and reset to 0.
- When undefined, these ports and counters do not exist and functional behaviour is identical.

Decomposition:
- Shared package cache_axi_pkg holds:
  - wr/rd type constants: RT_BYTE=3'b000, RT_HALF=3'b001, RT_WORD=3'b010, RT_LINE=3'b100.
  - LINE_OFF_W=4.
  - the wbuf entry struct typedef.
- One natural sub-module, wbuf_line_match: combinational DEPTH-way compare of the line tag against valid entries, producing hit.

Test Plan:
- Single line write 0x1C00_0040, out_wr_rdy=1 -> out_wr_req high one cycle after push, addr 0x1C00_0040, type 3'b100, wbuf_empty returns to 1 next cycle.
- DEPTH=2: push 3 writes back-to-back with out_wr_rdy=0 -> in_wr_rdy drops after the 2nd push, and the 3rd write is held until out_wr_rdy=1 pops the head.
- Buffered write to 0x1C00_0040, then in_rd_req to 0x1C00_004C -> out_rd_req=0 and in_rd_rdy=0 until the pop. Read to 0x1C00_0080 in the same state -> forwarded immediately.
- out_wr_rdy held 0 for 5 cycles -> out_wr_addr, out_wr_data and out_wr_type stable throughout; pop occurs exactly on the first cycle out_wr_rdy=1.
- aresetn asserted while 2 entries are buffered -> out_wr_req=0 and wbuf_empty=1 immediately (asynchronous); no stale write appears after release.
- WBUF_PERF_EN defined: 4 pushes and 3 hazard-stall cycles -> perf_wr_cnt=4, perf_stall_cnt=3.
